// File: rtl/divider_nbym_param.sv
// Sequential restoring divider, DVEND_W / DVSOR_W, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (sign-magnitude core).
module divider_nbym_param #(
    parameter int DVEND_W = 16,
    parameter int DVSOR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DVEND_W-1:0]         dividend,
    input  logic [DVSOR_W-1:0]         divisor,
    output logic [DVEND_W-DVSOR_W-1:0] quotient,
    output logic [DVSOR_W-1:0]         remainder,
    output logic                       v,
    output logic                       dz,
    output logic                       ready,
    output logic                       done
);

    localparam int QUOT_W = DVEND_W - DVSOR_W;
    localparam int CNT_W  = $clog2(QUOT_W + 1);

    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

    state_t             state;
    logic [DVEND_W-1:0] acc;
    logic [DVSOR_W-1:0] dsor;
    logic [CNT_W-1:0]   cnt;

    logic [DVEND_W:0]   acc_sh;
    logic [DVSOR_W:0]   trial;
    logic [DVEND_W-1:0] acc_nx;
    logic               ovf_chk;
    logic [DVEND_W-1:0] dend_ld;
    logic [DVSOR_W-1:0] dsor_ld;
    logic [QUOT_W-1:0]  q_mag;
    logic [DVSOR_W-1:0] r_mag;
    logic [QUOT_W-1:0]  q_fin;
    logic [DVSOR_W-1:0] r_fin;
    logic               v_fin;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    // Top DVSOR_W+1 bits after the shift never exceed 2*divisor-1,
    // so the MSB of the 9-bit difference is the borrow.
    assign acc_sh  = {acc, 1'b0};
    assign trial   = acc_sh[DVEND_W:QUOT_W] - {1'b0, dsor};
    assign acc_nx  = trial[DVSOR_W] ? acc_sh[DVEND_W-1:0]
                                    : {trial[DVSOR_W-1:0], acc_sh[QUOT_W-1:1], 1'b1};
    assign ovf_chk = {1'b0, acc[DVEND_W-1:QUOT_W]} >= {1'b0, dsor};
    assign q_mag   = acc_nx[QUOT_W-1:0];
    assign r_mag   = acc_nx[DVEND_W-1:QUOT_W];

    always_comb begin
        dend_ld = dividend;
        dsor_ld = divisor;
        q_fin   = q_mag;
        r_fin   = r_mag;
        v_fin   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        if (dividend[DVEND_W-1]) dend_ld = -dividend;
        if (divisor[DVSOR_W-1])  dsor_ld = -divisor;
        v_fin = q_mag[QUOT_W-1];
        if (neg_q) q_fin = -q_mag;
        if (neg_r) r_fin = -r_mag;
        if (v_fin) begin
            q_fin = '0;
            r_fin = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            dsor      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            v         <= 1'b0;
            dz        <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= dend_ld;
                        dsor  <= dsor_ld;
                        ready <= 1'b0;
                        state <= CHECK;
`ifdef DIVIDER_SIGNED_EN
                        neg_q <= dividend[DVEND_W-1] ^ divisor[DVSOR_W-1];
                        neg_r <= dividend[DVEND_W-1];
`endif
                    end
                end
                CHECK: begin
                    if (ovf_chk) begin
                        quotient  <= '0;
                        remainder <= '0;
                        v         <= 1'b1;
                        dz        <= (dsor == '0);
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt   <= CNT_W'(QUOT_W);
                        state <= ITER;
                    end
                end
                ITER: begin
                    acc <= acc_nx;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        v         <= v_fin;
                        dz        <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/divider_nbym_param.md
# divider_nbym_param

Parametrised sequential restoring divider: divides a `DVEND_W`-bit dividend by a `DVSOR_W`-bit divisor. It produces a `DVEND_W-DVSOR_W`-bit quotient and a `DVSOR_W`-bit remainder, using one shift-subtract step per clock. It sits in the arithmetic datapath as the generalised, resettable successor of the fixed 16/8 divider. It adds a start/ready/done handshake, a separate divide-by-zero flag, held results, and an optional signed mode.

## Interface
- `DVEND_W`, default 16: dividend width. Must be greater than `DVSOR_W`.
- `DVSOR_W`, default 8: divisor width and remainder width.
- `QUOT_W`, local, equals `DVEND_W-DVSOR_W`: quotient width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; accepted only while `ready`=1.
- `dividend` input `DVEND_W`: captured on the accept edge.
- `divisor` input `DVSOR_W`: captured on the accept edge.
- `quotient` output `QUOT_W`: held result.
- `remainder` output `DVSOR_W`: held result.
- `v` output 1: overflow, held with the result.
- `dz` output 1: divide-by-zero, held with the result; `dz`=1 implies `v`=1.
- `ready` output 1: high in IDLE only.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.

## Operation
- States: IDLE, CHECK, ITER, DONE.
- IDLE
  - `ready`=1.
  - `start`=1 loads accumulator = {1'b0, dividend}, loads the divisor register, then goes to CHECK.
- CHECK
  - Compares the upper `DVSOR_W` bits of the accumulator with the divisor using a (`DVSOR_W`+1)-bit compare.
  - If the upper bits are >= the divisor: `v`=1, `quotient`=0, `remainder`=0, go to DONE.
  - If the divisor is zero: additionally set `dz`=1.
  - Otherwise: go to ITER with the step counter set to `QUOT_W`.
- ITER, each cycle:
  - Shift the accumulator left by 1.
  - Trial-subtract the divisor from the top `DVSOR_W`+1 bits.
  - If there is no borrow, keep the difference and set quotient bit 1; else set quotient bit 0.
  - Decrement the counter; when it reaches 0, latch the outputs and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored; no queueing.
- Outputs hold the last result until the next CHECK/ITER completion overwrites them. They do not change during a new operation.
- Arithmetic is unsigned, with remainder < divisor always.
- The quotient fits exactly because the CHECK condition is false.

## Timing
- Reset (`rst_n`=0, any time including mid-operation):
  - State goes to IDLE.
  - `quotient`=0, `remainder`=0, `v`=0, `dz`=0, `done`=0, `ready`=1.
  - Any operation in progress is abandoned and produces no `done`.
- The accept edge is E0.
- Normal path:
  - ITER spans edges E2..E1+`QUOT_W`.
  - `done`=1 in the cycle after edge E1+`QUOT_W`, i.e. `QUOT_W`+2 cycles after E0 (10 for the defaults).
  - `ready`=1 again one cycle after `done`.
- Overflow / zero path: `done`=1 in the cycle after E1, i.e. 2 cycles after E0.
- Back-to-back throughput:
  - One operation every `QUOT_W`+3 cycles.
  - `start` held high continuously is accepted on the first IDLE cycle after each DONE.

## Configuration
- Macro: `DIVIDER_SIGNED_EN`.
- Defined:
  - Operands are two's complement.
  - Magnitudes are taken at load; the unsigned core runs on the magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - `v` is additionally set when the magnitude quotient has its MSB set, because it does not fit `QUOT_W`-1 bits. −2^(`QUOT_W`-1) is therefore flagged as overflow, with outputs zeroed.
  - The extra sign-fix happens combinationally at the ITER→DONE latch, so latency is unchanged.
- Undefined: purely unsigned; no sign logic is synthesised.

## Test plan
- Unsigned 1000/7 (0x03E8/0x07):
  - `quotient`=142, `remainder`=6, `v`=0.
  - `done` exactly 10 cycles after the accept edge.
- 0xFEFF/0xFF: `quotient`=255, `remainder`=254, `v`=0 (max non-overflow boundary).
- 0x1234/0x12: `v`=1, `dz`=0, `quotient`=0, `remainder`=0, `done` 2 cycles after accept.
- Divisor 0 with dividend 0x0005: `v`=1, `dz`=1, `done` 2 cycles after accept.
- `rst_n` pulsed low at ITER step 4:
  - All outputs cleared, `ready`=1, no `done` pulse.
  - A new 1000/7 then completes correctly.
- With `DIVIDER_SIGNED_EN`:
  - −100/7 (0xFF9C/0x07) gives `quotient`=0xF2 (−14), `remainder`=0xFE (−2), `v`=0.
  - −1000/7 gives `v`=1.
  - `start` held high throughout is accepted only once per IDLE.
